// File: rtl/ahf_xlink_arb.sv
// Three-source to three-mailbox message arbiter with round-robin grant and per-source four-phase Done.
// Latency: request sampled at edge N, mailboxes loaded and Done_out raised at edge N+1 when uncontended.
// Backpressure: a full mailbox (Mb_valid set) stalls the source in PEND until Rd frees it; no bypass.
module ahf_xlink_arb #(
  parameter int NCORE = 3,
  parameter int CNTW  = 16
) (
  input  logic                  Clk_pin0,
  input  logic                  Reset_pin,
  input  logic [3*NCORE-1:0]    Wr_mask,
  input  logic [14*NCORE-1:0]   Wr_data,
  output logic [NCORE-1:0]      Done_out,
  output logic [14*NCORE-1:0]   Mb_data,
  output logic [2*NCORE-1:0]    Mb_src,
  output logic [NCORE-1:0]      Mb_valid,
  input  logic [NCORE-1:0]      Rd,
  output logic [CNTW-1:0]       Xfer_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_ACK} state_t;

  state_t                    st_q [NCORE];
  state_t                    st_d [NCORE];
  logic [NCORE-1:0][NCORE-1:0] pend_q, pend_d;
  logic [NCORE-1:0][13:0]    data_q, data_d;
  logic [NCORE-1:0]          done_q, done_d;
  logic [NCORE-1:0][13:0]    mb_data_q, mb_data_d;
  logic [NCORE-1:0][1:0]     mb_src_q, mb_src_d;
  logic [NCORE-1:0]          mb_valid_q, mb_valid_d;
  logic [1:0]                last_q, last_d;
  logic [CNTW-1:0]           xfer_cnt_q, xfer_cnt_d;

  logic [NCORE-1:0]          elig;
  logic                      gnt_vld;
  logic [1:0]                gnt_idx;
  logic [1:0]                cand;
  logic [NCORE-1:0]          ld;
  logic [1:0]                ld_cnt;
  logic [NCORE-1:0]          rem;

  function automatic logic [1:0] next_idx(input logic [1:0] a);
    return (a == 2'd2) ? 2'd0 : a + 2'd1;
  endfunction

  // A source competes only while it has a target whose mailbox is currently empty.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NCORE; i++) begin
      elig[i] = (st_q[i] == S_PEND) && ((pend_q[i] & ~mb_valid_q) != '0);
    end
  end

  // Round-robin search starting just after the previous winner, wrapping once.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    cand    = next_idx(last_q);
    for (int k = 0; k < NCORE; k++) begin
      if (!gnt_vld && elig[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
      cand = next_idx(cand);
    end
  end

  // Mailbox side: load the winner's empty targets; reads free a slot for the following edge only.
  always_comb begin
    ld         = gnt_vld ? (pend_q[gnt_idx] & ~mb_valid_q) : '0;
    ld_cnt     = 2'd0;
    mb_data_d  = mb_data_q;
    mb_src_d   = mb_src_q;
    mb_valid_d = mb_valid_q;
    for (int d = 0; d < NCORE; d++) begin
      ld_cnt        = ld_cnt + {1'b0, ld[d]};
      mb_valid_d[d] = (mb_valid_q[d] & ~Rd[d]) | ld[d];
      if (ld[d]) begin
        mb_data_d[d] = data_q[gnt_idx];
        mb_src_d[d]  = gnt_idx;
      end
    end
    xfer_cnt_d = xfer_cnt_q + CNTW'(ld_cnt);
    last_d     = gnt_vld ? gnt_idx : last_q;
  end

  // Per-source IDLE/PEND/ACK sequencing with four-phase Done.
  always_comb begin
    pend_d = pend_q;
    data_d = data_q;
    done_d = done_q;
    rem    = '0;
    for (int i = 0; i < NCORE; i++) begin
      st_d[i] = st_q[i];
      case (st_q[i])
        S_IDLE: begin
          if (Wr_mask[3*i +: 3] != 3'b000) begin
            pend_d[i] = Wr_mask[3*i +: 3];
            data_d[i] = Wr_data[14*i +: 14];
            st_d[i]   = S_PEND;
          end
        end
        S_PEND: begin
          if (gnt_vld && (gnt_idx == 2'(i))) begin
            rem       = pend_q[i] & ~ld;
            pend_d[i] = rem;
            if (rem == '0) begin
              st_d[i]   = S_ACK;
              done_d[i] = 1'b1;
            end
          end
        end
        S_ACK: begin
          if (Wr_mask[3*i +: 3] == 3'b000) begin
            done_d[i] = 1'b0;
            st_d[i]   = S_IDLE;
          end
        end
        default: st_d[i] = S_IDLE;
      endcase
    end
  end

  // State registers; reset drops all pending and mailboxed words at once.
  always_ff @(posedge Clk_pin0 or negedge Reset_pin) begin
    if (!Reset_pin) begin
      for (int i = 0; i < NCORE; i++) st_q[i] <= S_IDLE;
      pend_q     <= '0;
      data_q     <= '0;
      done_q     <= '0;
      mb_data_q  <= '0;
      mb_src_q   <= '0;
      mb_valid_q <= '0;
      last_q     <= 2'd2;
      xfer_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NCORE; i++) st_q[i] <= st_d[i];
      pend_q     <= pend_d;
      data_q     <= data_d;
      done_q     <= done_d;
      mb_data_q  <= mb_data_d;
      mb_src_q   <= mb_src_d;
      mb_valid_q <= mb_valid_d;
      last_q     <= last_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign Done_out = done_q;
  assign Mb_data  = mb_data_q;
  assign Mb_src   = mb_src_q;
  assign Mb_valid = mb_valid_q;
  assign Xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_ahf_xlink_arb.sv
// Directed bench for ahf_xlink_arb; 4-bit transfer counter so that wrap is reached.
// Inputs are driven and outputs sampled on the falling edge.
// Mailboxes are drained explicitly with Rd between scenarios.
module tb_ahf_xlink_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [8:0]  wr_mask = '0;
  logic [41:0] wr_data = '0;
  logic [2:0]  rd = '0;
  logic [2:0]  done_out;
  logic [41:0] mb_data;
  logic [5:0]  mb_src;
  logic [2:0]  mb_valid;
  logic [3:0]  xfer_cnt;

  int errors = 0;
  int checks = 0;

  ahf_xlink_arb #(.NCORE(3), .CNTW(4)) dut (
    .Clk_pin0 (clk),
    .Reset_pin(rst_n),
    .Wr_mask  (wr_mask),
    .Wr_data  (wr_data),
    .Done_out (done_out),
    .Mb_data  (mb_data),
    .Mb_src   (mb_src),
    .Mb_valid (mb_valid),
    .Rd       (rd),
    .Xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic src(input int i, input logic [2:0] m, input logic [13:0] d);
    wr_mask[3*i +: 3]  = m;
    wr_data[14*i +: 14] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid", mb_valid, 3'b000);
    chk("rst_done", done_out, 3'b000);
    chk("rst_xfer", xfer_cnt, 4'd0);
    chk("rst_data", mb_data, 42'd0);
    @(negedge clk);
    tick();
    rst_n = 1'b1;

    // Round-robin from reset: order 0,1,2
    src(0, 3'b001, 14'h00AA);
    src(1, 3'b010, 14'h00BB);
    src(2, 3'b100, 14'h00CC);
    tick();
    wr_mask = '0;
    tick();
    chk("rrA_n1_valid", mb_valid, 3'b001);
    chk("rrA_n1_done", done_out, 3'b001);
    tick();
    chk("rrA_n2_valid", mb_valid, 3'b011);
    chk("rrA_n2_done", done_out, 3'b010);
    tick();
    chk("rrA_n3_valid", mb_valid, 3'b111);
    chk("rrA_n3_done", done_out, 3'b100);
    chk("rrA_src", mb_src, 6'h24);
    chk("rrA_data", mb_data, {14'h00CC, 14'h00BB, 14'h00AA});
    chk("rrA_xfer", xfer_cnt, 4'd3);
    tick();
    chk("rrA_done_low", done_out, 3'b000);
    rd = 3'b111;
    tick();
    rd = 3'b000;

    // Single write, latency and four-phase hold
    src(0, 3'b010, 14'h1ABC);
    tick();
    chk("single_n_valid", mb_valid, 3'b000);
    chk("single_n_done", done_out, 3'b000);
    tick();
    chk("single_valid", mb_valid, 3'b010);
    chk("single_data", mb_data[27:14], 14'h1ABC);
    chk("single_src", mb_src[3:2], 2'd0);
    chk("single_done", done_out, 3'b001);
    chk("single_xfer", xfer_cnt, 4'd4);
    tick();
    chk("single_hold_done", done_out, 3'b001);
    chk("single_hold_xfer", xfer_cnt, 4'd4);
    src(0, 3'b000, 14'h0000);
    tick();
    chk("single_done_drop", done_out, 3'b000);
    rd = 3'b010;
    tick();
    rd = 3'b000;
    chk("single_rd_valid", mb_valid, 3'b000);

    // Round-robin with last=0: order 1,2,0
    src(0, 3'b001, 14'h0111);
    src(1, 3'b010, 14'h0222);
    src(2, 3'b100, 14'h0333);
    tick();
    wr_mask = '0;
    tick();
    chk("rrB_n1_valid", mb_valid, 3'b010);
    chk("rrB_n1_done", done_out, 3'b010);
    tick();
    chk("rrB_n2_valid", mb_valid, 3'b110);
    chk("rrB_n2_done", done_out, 3'b100);
    tick();
    chk("rrB_n3_valid", mb_valid, 3'b111);
    chk("rrB_n3_done", done_out, 3'b001);
    chk("rrB_data", mb_data, {14'h0333, 14'h0222, 14'h0111});
    chk("rrB_xfer", xfer_cnt, 4'd7);
    tick();
    rd = 3'b111;
    tick();
    rd = 3'b000;

    // Contended destination 0: source 1 first, source 2 only after Rd, never same edge
    src(1, 3'b001, 14'h1111);
    src(2, 3'b001, 14'h2222);
    tick();
    wr_mask = '0;
    tick();
    chk("cont_first_valid", mb_valid, 3'b001);
    chk("cont_first_data", mb_data[13:0], 14'h1111);
    chk("cont_first_src", mb_src[1:0], 2'd1);
    chk("cont_first_done", done_out, 3'b010);
    chk("cont_first_xfer", xfer_cnt, 4'd8);
    tick();
    chk("cont_wait_done", done_out, 3'b000);
    chk("cont_wait_xfer", xfer_cnt, 4'd8);
    rd = 3'b001;
    tick();
    rd = 3'b000;
    chk("cont_m_valid", mb_valid, 3'b000);
    chk("cont_m_done", done_out, 3'b000);
    tick();
    chk("cont_m1_valid", mb_valid, 3'b001);
    chk("cont_m1_data", mb_data[13:0], 14'h2222);
    chk("cont_m1_src", mb_src[1:0], 2'd2);
    chk("cont_m1_done", done_out, 3'b100);
    chk("cont_m1_xfer", xfer_cnt, 4'd9);
    tick();
    rd = 3'b001;
    tick();
    rd = 3'b000;

    // Partial broadcast with mailbox 1 full
    src(0, 3'b010, 14'h0101);
    tick();
    src(0, 3'b000, 14'h0000);
    tick();
    chk("part_pre_valid", mb_valid, 3'b010);
    tick();
    src(2, 3'b111, 14'h3C3C);
    tick();
    src(2, 3'b000, 14'h0000);
    tick();
    chk("part_valid", mb_valid, 3'b111);
    chk("part_xfer", xfer_cnt, 4'd12);
    chk("part_done", done_out, 3'b000);
    chk("part_data", mb_data, {14'h3C3C, 14'h0101, 14'h3C3C});
    tick();
    chk("part_wait_done", done_out, 3'b000);
    chk("part_wait_xfer", xfer_cnt, 4'd12);
    rd = 3'b010;
    tick();
    rd = 3'b000;
    chk("part_m_valid", mb_valid, 3'b101);
    tick();
    chk("part_fin_valid", mb_valid, 3'b111);
    chk("part_fin_data", mb_data[27:14], 14'h3C3C);
    chk("part_fin_src", mb_src[3:2], 2'd2);
    chk("part_fin_done", done_out, 3'b100);
    chk("part_fin_xfer", xfer_cnt, 4'd13);
    tick();
    rd = 3'b111;
    tick();
    rd = 3'b000;

    // Latching: data changed while in PEND, mask kept high after Done
    src(0, 3'b100, 14'h0F0F);
    tick();
    src(0, 3'b100, 14'h3FFF);
    tick();
    chk("latch_data", mb_data[41:28], 14'h0F0F);
    chk("latch_done", done_out, 3'b001);
    chk("latch_xfer", xfer_cnt, 4'd14);
    rd = 3'b100;
    tick();
    rd = 3'b000;
    tick();
    tick();
    chk("latch_nodup_valid", mb_valid, 3'b000);
    chk("latch_nodup_xfer", xfer_cnt, 4'd14);
    chk("latch_hold_done", done_out, 3'b001);
    src(0, 3'b000, 14'h0000);
    tick();
    chk("latch_done_drop", done_out, 3'b000);

    // Counter wrap, then asynchronous reset with full mailboxes and a pending source
    src(1, 3'b111, 14'h1234);
    tick();
    src(1, 3'b000, 14'h0000);
    tick();
    chk("wrap_valid", mb_valid, 3'b111);
    chk("wrap_xfer", xfer_cnt, 4'd1);
    chk("wrap_src", mb_src, 6'h15);
    src(0, 3'b001, 14'h0555);
    tick();
    src(0, 3'b000, 14'h0000);
    tick();
    chk("full_wait_done", done_out, 3'b000);
    chk("full_wait_valid", mb_valid, 3'b111);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", mb_valid, 3'b000);
    chk("arst_data", mb_data, 42'd0);
    chk("arst_src", mb_src, 6'd0);
    chk("arst_xfer", xfer_cnt, 4'd0);
    chk("arst_done", done_out, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_valid", mb_valid, 3'b000);
    chk("post_rst_xfer", xfer_cnt, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
